// File: rtl/op_decoder_pkg.sv
// Shared opcode constants, source codes, decode-result type and decode function.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
//
// Contents: WRITE_A/WRITE_B/READ_C opcode values, src_t source codes,
// dec_t {write, source, illegal}, decode_op() mapping an opcode to dec_t.
package op_decoder_pkg;

  // Opcodes are compared at this width; callers zero-extend narrower opcodes
  // so that any set upper bit makes the opcode unrecognised.
  localparam int MAX_OP_W = 32;

  localparam logic [MAX_OP_W-1:0] WRITE_A = 32'd1;
  localparam logic [MAX_OP_W-1:0] WRITE_B = 32'd2;
  localparam logic [MAX_OP_W-1:0] READ_C  = 32'd11;

  typedef enum logic [1:0] {
    SRC_P0 = 2'd0,
    SRC_P1 = 2'd1,
    SRC_P2 = 2'd2,
    SRC_P3 = 2'd3
  } src_t;

  typedef struct packed {
    logic write;
    src_t source;
    logic illegal;
  } dec_t;

  function automatic dec_t decode_op(input logic [MAX_OP_W-1:0] op);
    dec_t d;
    d.write   = 1'b0;
    d.source  = SRC_P0;
    d.illegal = 1'b0;
    case (op)
      WRITE_A: begin d.write = 1'b1; d.source = SRC_P0; end
      WRITE_B: begin d.write = 1'b1; d.source = SRC_P2; end
      READ_C:  begin d.write = 1'b0; d.source = SRC_P3; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/op_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
// Latency: count updates on the edge where inc is sampled.
// Backpressure: none; inc is a single-cycle pulse per event.
//
// Ports: clk, rst (async, active-high), inc, clr, cnt[CNT_W-1:0].
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/op_decoder.sv
// Opcode decoder with a single registered output stage and accept statistics.
// Latency: one cycle from accept to out_valid; full throughput of one per cycle.
// Backpressure: in_ready = !out_valid || out_ready; result held while stalled.
//
// Ports: clk, rst (async, active-high); in_valid/in_ready/op_code input handshake;
// out_valid/out_ready with out_write, out_source, out_illegal result;
// clear_cnt clears write_cnt/read_cnt/illegal_cnt and err_sticky.
module op_decoder
  import op_decoder_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int SRC_W  = 2,
  parameter int CNT_W  = 8,
  parameter int STRICT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_write,
  output logic [SRC_W-1:0] out_source,
  output logic             out_illegal,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] write_cnt,
  output logic [CNT_W-1:0] read_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             err_sticky
);

  localparam bit DROP_ILLEGAL = (STRICT != 0);

  dec_t dec;
  logic accept;
  logic load;

  assign dec      = decode_op(MAX_OP_W'(op_code));
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // A dropped illegal opcode is still accepted (and counted) but never loaded.
  assign load     = accept && !(DROP_ILLEGAL && dec.illegal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_write   <= 1'b0;
      out_source  <= '0;
      out_illegal <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_write   <= dec.write;
      out_source  <= SRC_W'(dec.source);
      out_illegal <= dec.illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (clear_cnt) begin
      err_sticky <= 1'b0;
    end else if (accept && dec.illegal) begin
      err_sticky <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_write_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept && dec.write),
    .clr (clear_cnt),
    .cnt (write_cnt)
  );

  // Only READ_C decodes as neither write nor illegal.
  sat_counter #(.CNT_W(CNT_W)) u_read_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept && !dec.write && !dec.illegal),
    .clr (clear_cnt),
    .cnt (read_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_illegal_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept && dec.illegal),
    .clr (clear_cnt),
    .cnt (illegal_cnt)
  );

endmodule

// File: tb/tb_op_decoder.sv
// Directed bench for op_decoder: two instances share stimulus.
// u_a: OP_W=6, CNT_W=2, STRICT=0.  u_b: OP_W=4, CNT_W=8, STRICT=1 (sees op[3:0]).
module tb_op_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic       clear_cnt;
  logic [5:0] op;

  logic       a_in_ready, a_out_valid, a_out_write, a_out_illegal, a_err;
  logic [1:0] a_out_source, a_wcnt, a_rcnt, a_icnt;

  logic       b_in_ready, b_out_valid, b_out_write, b_out_illegal, b_err;
  logic [1:0] b_out_source;
  logic [7:0] b_wcnt, b_rcnt, b_icnt;

  int n_vec = 0;
  int n_err = 0;

  op_decoder #(.OP_W(6), .SRC_W(2), .CNT_W(2), .STRICT(0)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready), .op_code(op),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_write(a_out_write), .out_source(a_out_source), .out_illegal(a_out_illegal),
    .clear_cnt(clear_cnt),
    .write_cnt(a_wcnt), .read_cnt(a_rcnt), .illegal_cnt(a_icnt),
    .err_sticky(a_err)
  );

  op_decoder #(.OP_W(4), .SRC_W(2), .CNT_W(8), .STRICT(1)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready), .op_code(op[3:0]),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_write(b_out_write), .out_source(b_out_source), .out_illegal(b_out_illegal),
    .clear_cnt(clear_cnt),
    .write_cnt(b_wcnt), .read_cnt(b_rcnt), .illegal_cnt(b_icnt),
    .err_sticky(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_cnt = 1'b0; op = 6'd0;
    step(); step();

    // Reset state
    chk("rst_valid",   32'(a_out_valid), 32'd0);
    chk("rst_write",   32'(a_out_write), 32'd0);
    chk("rst_source",  32'(a_out_source), 32'd0);
    chk("rst_illegal", 32'(a_out_illegal), 32'd0);
    chk("rst_wcnt",    32'(a_wcnt), 32'd0);
    chk("rst_err",     32'(a_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);

    // Stream 1, 2, 11 at full rate
    in_valid = 1'b1; op = 6'd1;
    step();
    chk("s1_valid",  32'(a_out_valid), 32'd1);
    chk("s1_write",  32'(a_out_write), 32'd1);
    chk("s1_source", 32'(a_out_source), 32'd0);
    op = 6'd2;
    step();
    chk("s2_valid",  32'(a_out_valid), 32'd1);
    chk("s2_write",  32'(a_out_write), 32'd1);
    chk("s2_source", 32'(a_out_source), 32'd2);
    op = 6'd11;
    step();
    chk("s3_valid",   32'(a_out_valid), 32'd1);
    chk("s3_write",   32'(a_out_write), 32'd0);
    chk("s3_source",  32'(a_out_source), 32'd3);
    chk("s3_illegal", 32'(a_out_illegal), 32'd0);
    in_valid = 1'b0;
    step();
    chk("s_drain_valid", 32'(a_out_valid), 32'd0);
    chk("s_wcnt",   32'(a_wcnt), 32'd2);
    chk("s_rcnt",   32'(a_rcnt), 32'd1);
    chk("s_b_wcnt", 32'(b_wcnt), 32'd2);
    chk("s_b_rcnt", 32'(b_rcnt), 32'd1);

    // Backpressure: hold opcode 2 for five cycles, then release
    in_valid = 1'b1; op = 6'd2;
    step();
    chk("bp_load_source", 32'(a_out_source), 32'd2);
    out_ready = 1'b0; op = 6'd1;
    #1;
    chk("bp_in_ready_low", 32'(a_in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_ready",  32'(a_in_ready), 32'd0);
      chk("bp_hold_valid",  32'(a_out_valid), 32'd1);
      chk("bp_hold_source", 32'(a_out_source), 32'd2);
      chk("bp_hold_write",  32'(a_out_write), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_in_ready), 32'd1);
    step();
    chk("bp_next_valid",  32'(a_out_valid), 32'd1);
    chk("bp_next_source", 32'(a_out_source), 32'd0);
    chk("bp_next_write",  32'(a_out_write), 32'd1);
    chk("bp_wcnt_sat",    32'(a_wcnt), 32'd3);
    chk("bp_b_wcnt",      32'(b_wcnt), 32'd4);
    in_valid = 1'b0;
    step();

    // Saturation and clear-wins
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1; op = 6'd1;
    for (int i = 0; i < 5; i++) step();
    chk("sat_a_wcnt", 32'(a_wcnt), 32'd3);
    chk("sat_b_wcnt", 32'(b_wcnt), 32'd5);
    clear_cnt = 1'b1; op = 6'd2;
    step();
    clear_cnt = 1'b0;
    chk("clr_a_wcnt",   32'(a_wcnt), 32'd0);
    chk("clr_b_wcnt",   32'(b_wcnt), 32'd0);
    chk("clr_valid",    32'(a_out_valid), 32'd1);
    chk("clr_source",   32'(a_out_source), 32'd2);

    // Async reset mid-transfer
    out_ready = 1'b0;
    step();
    chk("ar_pre_valid", 32'(a_out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_valid",  32'(a_out_valid), 32'd0);
    chk("ar_write",  32'(a_out_write), 32'd0);
    chk("ar_source", 32'(a_out_source), 32'd0);
    chk("ar_b_valid", 32'(b_out_valid), 32'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("ar_in_ready", 32'(a_in_ready), 32'd1);
    out_ready = 1'b1;

    // Illegal opcode 7: forwarded by u_a, dropped by u_b
    in_valid = 1'b1; op = 6'd7;
    step();
    chk("il_valid",   32'(a_out_valid), 32'd1);
    chk("il_illegal", 32'(a_out_illegal), 32'd1);
    chk("il_write",   32'(a_out_write), 32'd0);
    chk("il_source",  32'(a_out_source), 32'd0);
    chk("il_err",     32'(a_err), 32'd1);
    chk("il_b_valid", 32'(b_out_valid), 32'd0);
    chk("il_b_icnt",  32'(b_icnt), 32'd1);
    chk("il_b_err",   32'(b_err), 32'd1);

    // Wide opcode: 11 decodes, 43 does not
    op = 6'd11;
    step();
    chk("w11_source",  32'(a_out_source), 32'd3);
    chk("w11_illegal", 32'(a_out_illegal), 32'd0);
    op = 6'd43;
    step();
    chk("w43_illegal", 32'(a_out_illegal), 32'd1);
    chk("w43_source",  32'(a_out_source), 32'd0);
    chk("w43_icnt",    32'(a_icnt), 32'd2);

    // Clear with a concurrent illegal accept: clear wins, output still loads
    clear_cnt = 1'b1; op = 6'd7;
    step();
    clear_cnt = 1'b0;
    in_valid = 1'b0;
    chk("ci_err",     32'(a_err), 32'd0);
    chk("ci_icnt",    32'(a_icnt), 32'd0);
    chk("ci_valid",   32'(a_out_valid), 32'd1);
    chk("ci_illegal", 32'(a_out_illegal), 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/op_decoder.md
OP_DECODER -- requirements
Module: op_decoder

Interface
REQ-001 Parameter OP_W, default 4: opcode width; SHALL be at least 4.
REQ-002 Parameter SRC_W, default 2: source field width; SHALL be at least 2.
REQ-003 Parameter CNT_W, default 8: width of each statistics counter.
REQ-004 Parameter STRICT, default 0: 0 forwards illegal opcodes flagged; 1 drops them.
REQ-005 Port clk, input, 1: single clock; all state on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port in_valid, input, 1: op_code is valid this cycle.
REQ-008 Port in_ready, output, 1: block accepts op_code this cycle.
REQ-009 Port op_code, input, OP_W: opcode to decode.
REQ-010 Port out_valid, output, 1: decoded result is valid.
REQ-011 Port out_ready, input, 1: consumer accepts the result.
REQ-012 Port out_write, output, 1: decoded write enable.
REQ-013 Port out_source, output, SRC_W: decoded source select.
REQ-014 Port out_illegal, output, 1: forwarded opcode was not recognised.
REQ-015 Port clear_cnt, input, 1: synchronous clear of counters and sticky flag.
REQ-016 Port write_cnt, read_cnt and illegal_cnt, outputs, CNT_W each: accepted-opcode statistics.
REQ-017 Port err_sticky, output, 1: set on the first accepted illegal opcode.

Function
REQ-018 Accept event: in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready.
REQ-019 Decode table, opcode zero-extended to OP_W:
- WRITE_A=1 -> write 1, source 0.
- WRITE_B=2 -> write 1, source 2.
- READ_C=11 -> write 0, source 3.
- Any other opcode -> illegal; write 0, source 0; no X on any output.
REQ-020 Latency SHALL be one cycle: an opcode accepted at edge N appears with out_valid high after edge N.
REQ-021 While out_valid && !out_ready, out_write, out_source and out_illegal SHALL hold stable.
REQ-022 out_valid SHALL clear when the output is taken (out_valid && out_ready) and no new opcode is accepted on the same edge.
REQ-023 Simultaneous take and accept SHALL load the new result with out_valid remaining high (full throughput, one per cycle).
REQ-024 With STRICT=1, an accepted illegal opcode SHALL NOT set out_valid but SHALL still be counted and set err_sticky.
REQ-025 Counters: write_cnt increments on accepted WRITE_A/B; read_cnt increments on accepted READ_C; illegal_cnt increments on accepted illegal opcodes.
REQ-026 Each counter SHALL saturate at all-ones and never wrap.
REQ-027 clear_cnt coincident with a counting accept: clear wins; counter is 0 and err_sticky is 0 after the edge.
REQ-028 clear_cnt SHALL NOT affect the output register or the handshake.

Reset
REQ-029 rst SHALL asynchronously force out_valid=0, out_write=0, out_source=0, out_illegal=0, all counters=0 and err_sticky=0.
REQ-030 Reset asserted mid-transfer SHALL discard any held result; in_ready is 1 on the first cycle after deassertion.

Structure
REQ-031 Package op_decoder_pkg SHALL hold:
- Opcode constants WRITE_A, WRITE_B and READ_C.
- Source codes.
- A packed decode-result struct {write, source, illegal}.
REQ-032 Decoding SHALL be a pure function in op_decoder_pkg.
REQ-033 One sub-module, sat_counter (parameter CNT_W; inc/clr inputs; clear priority), SHALL be instantiated three times.

Verification
REQ-034 Reset, then stream 1, 2, 11 with out_ready=1 -> outputs (1,0), (1,2), (0,3) on consecutive cycles; write_cnt=2, read_cnt=1.
REQ-035 Backpressure: out_ready=0 after accepting 2 -> in_ready=0 and out_source=2 held for 5 cycles; release -> next opcode accepted the same cycle.
REQ-036 STRICT=0, opcode 7 -> out_valid=1, out_illegal=1, write=0, source=0, err_sticky=1; STRICT=1 -> out_valid stays 0 and illegal_cnt=1.
REQ-037 CNT_W=2, five WRITE_A accepts -> write_cnt=3; clear_cnt with a concurrent WRITE_B accept -> write_cnt=0.
REQ-038 Assert rst while out_valid=1 and out_ready=0 -> all outputs 0 immediately (before the next clk edge); in_ready=1 after deassertion.
REQ-039 OP_W=6, opcodes 6'd11 and 6'd43 -> READ_C decode and illegal respectively.
